// File: rtl/conv_pkg.sv
// Shared definitions for the CNN accelerator host memory responder:
// widths, bank depths, bank-select encodings and the handshake state type.
package conv_pkg;

    localparam int CONV_AW       = 12;
    localparam int CONV_DW       = 20;
    localparam int CONV_L0_DEPTH = 4096;
    localparam int CONV_L1_DEPTH = 1024;
    localparam int CONV_L2_DEPTH = 2048;
    localparam int WDOG_W        = 24;

    // csel / dbg_sel encodings; 000 selects the image only on the debug path
    localparam logic [2:0] CSEL_IMG   = 3'b000;
    localparam logic [2:0] CSEL_L0_K0 = 3'b001;
    localparam logic [2:0] CSEL_L0_K1 = 3'b010;
    localparam logic [2:0] CSEL_L1_K0 = 3'b011;
    localparam logic [2:0] CSEL_L1_K1 = 3'b100;
    localparam logic [2:0] CSEL_L2    = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RUN,
        ST_FIN
    } conv_state_t;

endpackage

// File: rtl/conv_bank_ram.sv
// Simple storage array: one posedge write port, one async read port and one
// async debug read port. Contents are never cleared by reset.
module conv_bank_ram #(
    parameter int DEPTH = 4096,
    parameter int DW    = 20,
    parameter int ABITS = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ABITS-1:0] waddr,
    input  logic [DW-1:0]    wdata,
    input  logic [ABITS-1:0] raddr,
    output logic [DW-1:0]    rdata,
    input  logic [ABITS-1:0] daddr,
    output logic [DW-1:0]    ddata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Async reads see the pre-edge contents, so a same-cycle write returns old data
    assign rdata = mem[raddr];
    assign ddata = mem[daddr];

endmodule

// File: rtl/conv_mem_host.sv
// Host-side responder: image ROM, five result banks, ready/busy start handshake.
// Optional watchdog on REQ/RUN enabled by defining CONV_HOST_WDOG_EN.
module conv_mem_host
    import conv_pkg::*;
#(
    parameter int AW       = CONV_AW,
    parameter int DW       = CONV_DW,
    parameter int L1_DEPTH = CONV_L1_DEPTH,
    parameter int L2_DEPTH = CONV_L2_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          img_we,
    input  logic [AW-1:0] img_addr,
    input  logic [DW-1:0] img_data,
    output logic          ready,
    input  logic          busy,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] idata,
    input  logic          crd,
    input  logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_rd,
    input  logic          cwr,
    input  logic [AW-1:0] caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    input  logic [2:0]    csel,
    output logic          done,
    output logic          err,
    input  logic [2:0]    dbg_sel,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    localparam int          L0_DEPTH = 1 << AW;
    localparam int          L1_AB    = $clog2(L1_DEPTH);
    localparam int          L2_AB    = $clog2(L2_DEPTH);
    localparam logic [AW:0] L1_LIM   = (AW+1)'(L1_DEPTH);
    localparam logic [AW:0] L2_LIM   = (AW+1)'(L2_DEPTH);

    conv_state_t state, next_state;
    logic        busy_q;
    logic        wdog_trip;
    logic        rd_ok, wr_ok;
    logic        img_we_ok, img_we_bad;
    logic        err_set;

    logic [DW-1:0] l0k0_rdata, l0k1_rdata, l1k0_rdata, l1k1_rdata, l2_rdata;
    logic [DW-1:0] l0k0_ddata, l0k1_ddata, l1k0_ddata, l1k1_ddata, l2_ddata;
    logic [DW-1:0] img_ddata;

    // Bank address legality; unmapped selects are never in range
    function automatic logic addr_ok(input logic [2:0] sel, input logic [AW-1:0] addr);
        case (sel)
            CSEL_L0_K0, CSEL_L0_K1: addr_ok = 1'b1;
            CSEL_L1_K0, CSEL_L1_K1: addr_ok = ({1'b0, addr} < L1_LIM);
            CSEL_L2:                addr_ok = ({1'b0, addr} < L2_LIM);
            default:                addr_ok = 1'b0;
        endcase
    endfunction

    assign rd_ok      = addr_ok(csel, caddr_rd);
    assign wr_ok      = addr_ok(csel, caddr_wr);
    assign img_we_ok  = img_we && (state == ST_IDLE);
    assign img_we_bad = img_we && (state != ST_IDLE);
    assign err_set    = img_we_bad | (crd & ~rd_ok) | (cwr & ~wr_ok) | wdog_trip;

    assign ready = (state == ST_REQ);
    assign done  = (state == ST_FIN);

`ifdef CONV_HOST_WDOG_EN
    logic [WDOG_W-1:0] wdog_cnt;

    // Counts only while waiting on the accelerator; any other state clears it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_cnt <= '0;
        end else if (state == ST_REQ || state == ST_RUN) begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end else begin
            wdog_cnt <= '0;
        end
    end

    assign wdog_trip = (state == ST_REQ || state == ST_RUN) && (wdog_cnt == '1);
`else
    assign wdog_trip = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= next_state;
            busy_q <= busy;
            err    <= err | err_set;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start) next_state = ST_REQ;
            ST_REQ:  if (busy) next_state = ST_RUN;
            ST_RUN:  if (busy_q && !busy) next_state = ST_FIN;
            ST_FIN:  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
        if (wdog_trip) begin
            next_state = ST_FIN;
        end
    end

    conv_bank_ram #(.DEPTH(L0_DEPTH), .DW(DW), .ABITS(AW)) u_img (
        .clk   (clk),
        .we    (img_we_ok),
        .waddr (img_addr),
        .wdata (img_data),
        .raddr (iaddr),
        .rdata (idata),
        .daddr (dbg_addr),
        .ddata (img_ddata)
    );

    conv_bank_ram #(.DEPTH(L0_DEPTH), .DW(DW), .ABITS(AW)) u_l0_k0 (
        .clk   (clk),
        .we    (cwr && wr_ok && (csel == CSEL_L0_K0)),
        .waddr (caddr_wr),
        .wdata (cdata_wr),
        .raddr (caddr_rd),
        .rdata (l0k0_rdata),
        .daddr (dbg_addr),
        .ddata (l0k0_ddata)
    );

    conv_bank_ram #(.DEPTH(L0_DEPTH), .DW(DW), .ABITS(AW)) u_l0_k1 (
        .clk   (clk),
        .we    (cwr && wr_ok && (csel == CSEL_L0_K1)),
        .waddr (caddr_wr),
        .wdata (cdata_wr),
        .raddr (caddr_rd),
        .rdata (l0k1_rdata),
        .daddr (dbg_addr),
        .ddata (l0k1_ddata)
    );

    // L1/L2 banks only see the low address bits; range checks above gate writes
    conv_bank_ram #(.DEPTH(L1_DEPTH), .DW(DW), .ABITS(L1_AB)) u_l1_k0 (
        .clk   (clk),
        .we    (cwr && wr_ok && (csel == CSEL_L1_K0)),
        .waddr (caddr_wr[L1_AB-1:0]),
        .wdata (cdata_wr),
        .raddr (caddr_rd[L1_AB-1:0]),
        .rdata (l1k0_rdata),
        .daddr (dbg_addr[L1_AB-1:0]),
        .ddata (l1k0_ddata)
    );

    conv_bank_ram #(.DEPTH(L1_DEPTH), .DW(DW), .ABITS(L1_AB)) u_l1_k1 (
        .clk   (clk),
        .we    (cwr && wr_ok && (csel == CSEL_L1_K1)),
        .waddr (caddr_wr[L1_AB-1:0]),
        .wdata (cdata_wr),
        .raddr (caddr_rd[L1_AB-1:0]),
        .rdata (l1k1_rdata),
        .daddr (dbg_addr[L1_AB-1:0]),
        .ddata (l1k1_ddata)
    );

    conv_bank_ram #(.DEPTH(L2_DEPTH), .DW(DW), .ABITS(L2_AB)) u_l2 (
        .clk   (clk),
        .we    (cwr && wr_ok && (csel == CSEL_L2)),
        .waddr (caddr_wr[L2_AB-1:0]),
        .wdata (cdata_wr),
        .raddr (caddr_rd[L2_AB-1:0]),
        .rdata (l2_rdata),
        .daddr (dbg_addr[L2_AB-1:0]),
        .ddata (l2_ddata)
    );

    always_comb begin
        cdata_rd = '0;
        if (crd && rd_ok) begin
            case (csel)
                CSEL_L0_K0: cdata_rd = l0k0_rdata;
                CSEL_L0_K1: cdata_rd = l0k1_rdata;
                CSEL_L1_K0: cdata_rd = l1k0_rdata;
                CSEL_L1_K1: cdata_rd = l1k1_rdata;
                CSEL_L2:    cdata_rd = l2_rdata;
                default:    cdata_rd = '0;
            endcase
        end
    end

    // Debug readback never raises err; illegal selects or addresses read as zero
    always_comb begin
        dbg_data = '0;
        if (dbg_sel == CSEL_IMG) begin
            dbg_data = img_ddata;
        end else if (addr_ok(dbg_sel, dbg_addr)) begin
            case (dbg_sel)
                CSEL_L0_K0: dbg_data = l0k0_ddata;
                CSEL_L0_K1: dbg_data = l0k1_ddata;
                CSEL_L1_K0: dbg_data = l1k0_ddata;
                CSEL_L1_K1: dbg_data = l1k1_ddata;
                CSEL_L2:    dbg_data = l2_ddata;
                default:    dbg_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_mem_host.sv
// Testbench for conv_mem_host: directed handshake/range steps plus randomized
// bank traffic compared against an array-based reference model.
module tb_conv_mem_host;

    localparam int AW = 12;
    localparam int DW = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, img_we, busy, crd, cwr;
    logic [AW-1:0] img_addr, iaddr, caddr_rd, caddr_wr, dbg_addr;
    logic [DW-1:0] img_data, cdata_wr;
    logic [2:0]    csel, dbg_sel;
    logic          ready, done, err;
    logic [DW-1:0] idata, cdata_rd, dbg_data;

    int errors = 0;
    int checks = 0;

    // Reference model: index 0 is the image, 1..5 follow the csel encoding
    logic [DW-1:0] mdl   [0:5][0:4095];
    bit            known [0:5][0:4095];
    bit            err_m;

    always #5 clk = ~clk;

    conv_mem_host dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .img_we   (img_we),
        .img_addr (img_addr),
        .img_data (img_data),
        .ready    (ready),
        .busy     (busy),
        .iaddr    (iaddr),
        .idata    (idata),
        .crd      (crd),
        .caddr_rd (caddr_rd),
        .cdata_rd (cdata_rd),
        .cwr      (cwr),
        .caddr_wr (caddr_wr),
        .cdata_wr (cdata_wr),
        .csel     (csel),
        .done     (done),
        .err      (err),
        .dbg_sel  (dbg_sel),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    function automatic int depth_of(input logic [2:0] sel);
        case (sel)
            3'd0, 3'd1, 3'd2: return 4096;
            3'd3, 3'd4:       return 1024;
            3'd5:             return 2048;
            default:          return 0;
        endcase
    endfunction

    function automatic bit bank_ok(input logic [2:0] sel, input logic [AW-1:0] a);
        return (sel >= 3'd1) && (sel <= 3'd5) && (int'(a) < depth_of(sel));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] sel,
                                 input logic [AW-1:0] ard, input logic [AW-1:0] awr,
                                 input logic [DW-1:0] wd);
        crd = rd; cwr = wr; csel = sel;
        caddr_rd = ard; caddr_wr = awr; cdata_wr = wd;
        #1;
    endtask

    // One bank-port cycle: check read data before the edge, update model after it
    task automatic do_cycle(input string tag, input logic rd, input logic wr, input logic [2:0] sel,
                            input logic [AW-1:0] ard, input logic [AW-1:0] awr,
                            input logic [DW-1:0] wd);
        bit bad;
        applyStimulus(rd, wr, sel, ard, awr, wd);
        if (rd && bank_ok(sel, ard)) begin
            if (known[sel][ard]) checkOutput({tag, "_rd"}, 32'(cdata_rd), 32'(mdl[sel][ard]));
        end else begin
            checkOutput({tag, "_rd_zero"}, 32'(cdata_rd), 32'd0);
        end
        bad = (rd && !bank_ok(sel, ard)) || (wr && !bank_ok(sel, awr));
        tick();
        crd = 1'b0; cwr = 1'b0;
        if (wr && bank_ok(sel, awr)) begin
            mdl[sel][awr]   = wd;
            known[sel][awr] = 1'b1;
        end
        if (bad) err_m = 1'b1;
        checkOutput({tag, "_err"}, 32'(err), 32'(err_m));
    endtask

    task automatic img_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit accept);
        img_addr = a; img_data = d; img_we = 1'b1;
        tick();
        img_we = 1'b0;
        if (accept) begin
            mdl[0][a]   = d;
            known[0][a] = 1'b1;
        end else begin
            err_m = 1'b1;
        end
    endtask

    task automatic img_check(input string tag, input logic [AW-1:0] a);
        iaddr = a; dbg_sel = 3'd0; dbg_addr = a;
        #1;
        checkOutput({tag, "_idata"}, 32'(idata), 32'(mdl[0][a]));
        checkOutput({tag, "_dbg"}, 32'(dbg_data), 32'(mdl[0][a]));
    endtask

    task automatic do_reset();
        start = 1'b0; img_we = 1'b0; busy = 1'b0; crd = 1'b0; cwr = 1'b0;
        reset = 1'b0;
        #2;
        checkOutput("rst_ready", 32'(ready), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        err_m = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        logic [AW-1:0] a;
        logic [AW-1:0] img_q [$];
        logic [2:0]    s;
        logic [DW-1:0] d;

        start = 1'b0; img_we = 1'b0; busy = 1'b0; crd = 1'b0; cwr = 1'b0;
        img_addr = '0; img_data = '0; iaddr = '0; caddr_rd = '0; caddr_wr = '0;
        cdata_wr = '0; csel = '0; dbg_sel = '0; dbg_addr = '0;
        reset = 1'b0;
        tick();
        do_reset();

        // Image load in IDLE, then zero-latency readback
        for (int i = 0; i < 12; i++) begin
            a = AW'($urandom_range(0, 4095));
            img_write(a, DW'($urandom), 1'b1);
            img_q.push_back(a);
        end
        img_write(12'h041, 20'h12345, 1'b1);
        img_q.push_back(12'h041);
        foreach (img_q[i]) img_check("img", img_q[i]);
        iaddr = 12'h041; #1;
        checkOutput("img_041_const", 32'(idata), 32'h12345);

        // L0 banks are independent at the same address
        do_cycle("l0k1_wr", 1'b0, 1'b1, 3'd2, '0, 12'hFFF, 20'h55AA5);
        do_cycle("l0k0_wr", 1'b0, 1'b1, 3'd1, '0, 12'hFFF, 20'h0ABCD);
        applyStimulus(1'b1, 1'b0, 3'd1, 12'hFFF, '0, '0);
        checkOutput("l0k0_fff", 32'(cdata_rd), 32'h0ABCD);
        applyStimulus(1'b1, 1'b0, 3'd2, 12'hFFF, '0, '0);
        checkOutput("l0k1_fff", 32'(cdata_rd), 32'h55AA5);
        crd = 1'b0; #1;
        checkOutput("crd_low_zero", 32'(cdata_rd), 32'd0);

        // L1 range boundary: 0x400 must not alias onto entry 0
        do_cycle("l1_wr0", 1'b0, 1'b1, 3'd3, '0, 12'h000, 20'h11111);
        do_cycle("l1_wr3ff", 1'b0, 1'b1, 3'd3, '0, 12'h3FF, 20'h33333);
        checkOutput("l1_err_clean", 32'(err), 32'd0);
        do_cycle("l1_wr400", 1'b0, 1'b1, 3'd3, '0, 12'h400, 20'h22222);
        checkOutput("l1_err_set", 32'(err), 32'd1);
        do_cycle("l1_rd0", 1'b1, 1'b0, 3'd3, 12'h000, '0, '0);
        do_cycle("l1_rd3ff", 1'b1, 1'b0, 3'd3, 12'h3FF, '0, '0);
        do_cycle("l1_rd400", 1'b1, 1'b0, 3'd3, 12'h400, '0, '0);
        dbg_sel = 3'd3; dbg_addr = 12'h400; #1;
        checkOutput("dbg_l1_oor", 32'(dbg_data), 32'd0);

        // Bad select after reset; bank data survives reset
        do_reset();
        do_cycle("l0k0_keep", 1'b1, 1'b0, 3'd1, 12'hFFF, '0, '0);
        applyStimulus(1'b1, 1'b0, 3'd6, 12'h000, '0, '0);
        checkOutput("sel6_zero", 32'(cdata_rd), 32'd0);
        do_cycle("sel6", 1'b1, 1'b0, 3'd6, 12'h000, '0, '0);
        checkOutput("sel6_err", 32'(err), 32'd1);

        // L2 read-during-write returns old value, new value next cycle
        do_reset();
        do_cycle("l2_wr1", 1'b0, 1'b1, 3'd5, '0, 12'h7FF, 20'h00001);
        applyStimulus(1'b1, 1'b1, 3'd5, 12'h7FF, 12'h7FF, 20'h00002);
        checkOutput("rdw_old", 32'(cdata_rd), 32'h00001);
        do_cycle("rdw", 1'b1, 1'b1, 3'd5, 12'h7FF, 12'h7FF, 20'h00002);
        applyStimulus(1'b1, 1'b0, 3'd5, 12'h7FF, '0, '0);
        checkOutput("rdw_new", 32'(cdata_rd), 32'h00002);
        do_cycle("l2_rd800", 1'b1, 1'b0, 3'd5, 12'h800, '0, '0);

        // Handshake: ready waits for busy, done pulses once after busy falls
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        checkOutput("hs_ready_up", 32'(ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("hs_ready_hold", 32'(ready), 32'd1);
        end
        busy = 1'b1; tick();
        checkOutput("hs_ready_drop", 32'(ready), 32'd0);
        checkOutput("hs_done_run", 32'(done), 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        checkOutput("hs_start_ign", 32'(ready), 32'd0);
        d = DW'($urandom);
        do_cycle("run_wr", 1'b0, 1'b1, 3'd4, '0, 12'h010, d);
        do_cycle("run_rd", 1'b1, 1'b0, 3'd4, 12'h010, '0, '0);
        img_write(12'h041, 20'hFFFFF, 1'b0);
        checkOutput("run_imgwe_err", 32'(err), 32'd1);
        img_check("run_img_keep", 12'h041);
        busy = 1'b0; tick();
        checkOutput("hs_done_up", 32'(done), 32'd1);
        tick();
        checkOutput("hs_done_drop", 32'(done), 32'd0);
        checkOutput("hs_idle_ready", 32'(ready), 32'd0);
        tick();
        checkOutput("hs_no_rerun", 32'(ready), 32'd0);

        // Reset while in RUN: outputs clear, written data retained
        start = 1'b1; tick(); start = 1'b0;
        busy = 1'b1; tick();
        do_cycle("mid_wr", 1'b0, 1'b1, 3'd1, '0, 12'h123, 20'h6789A);
        reset = 1'b0; #1;
        checkOutput("mid_ready", 32'(ready), 32'd0);
        checkOutput("mid_done", 32'(done), 32'd0);
        checkOutput("mid_err", 32'(err), 32'd0);
        err_m = 1'b0;
        busy = 1'b0;
        tick();
        reset = 1'b1;
        dbg_sel = 3'd1; dbg_addr = 12'h123; #1;
        checkOutput("mid_dbg_l0", 32'(dbg_data), 32'h6789A);
        start = 1'b1; tick(); start = 1'b0;
        checkOutput("mid_idle_start", 32'(ready), 32'd1);
        busy = 1'b1; tick();
        busy = 1'b0; tick();
        checkOutput("mid_done_pulse", 32'(done), 32'd1);
        tick();

        // Randomized bank traffic with boundary-biased addresses
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] ar, aw;
            s = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) s = 3'd6 + 3'($urandom_range(0, 1));
            else s = 3'($urandom_range(1, 5));
            case ($urandom_range(0, 5))
                0:       begin ar = 12'h3F8 + AW'($urandom_range(0, 15)); aw = 12'h3F8 + AW'($urandom_range(0, 15)); end
                1:       begin ar = 12'h7F8 + AW'($urandom_range(0, 15)); aw = 12'h7F8 + AW'($urandom_range(0, 15)); end
                2:       begin ar = AW'($urandom); aw = AW'($urandom); end
                default: begin ar = AW'($urandom_range(0, 15)); aw = AW'($urandom_range(0, 15)); end
            endcase
            do_cycle("rand", 1'($urandom), 1'($urandom), s, ar, aw, DW'($urandom));
        end
        for (int sv = 1; sv <= 5; sv++) begin
            for (int ai = 0; ai < 16; ai++) begin
                if (known[sv][ai]) begin
                    dbg_sel = 3'(sv); dbg_addr = AW'(ai); #1;
                    checkOutput("rand_dbg", 32'(dbg_data), 32'(mdl[sv][ai]));
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_mem_host.md
Name: conv_mem_host

Overview:
Host-side responder for the layered CNN accelerator memory interface. It serves the image ROM (iaddr/idata) and the five result banks (crd/cwr/csel/caddr_rd/caddr_wr/cdata_rd/cdata_wr), and runs the ready/busy start handshake. It also reports completion and gives a debug readback path so the SoC or bench can load images and check layer outputs.

Parameters:
AW, 12, address width of image and bank ports
DW, 20, data width (signed Q4.16 for image, layer data as written)
L1_DEPTH, 1024, entries in each L1 bank (csel 3'b011, 3'b100)
L2_DEPTH, 2048, entries in L2 bank (csel 3'b101)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle request to launch one run
img_we  in  1  image load write strobe
img_addr  in  AW  image load address
img_data  in  DW  image load data
ready  out  1  start request to accelerator
busy  in  1  accelerator busy
iaddr  in  AW  image read address
idata  out  DW  image read data
crd  in  1  bank read enable
caddr_rd  in  AW  bank read address
cdata_rd  out  DW  bank read data
cwr  in  1  bank write enable
caddr_wr  in  AW  bank write address
cdata_wr  in  DW  bank write data
csel  in  3  bank select: 001 L0_K0, 010 L0_K1, 011 L1_K0, 100 L1_K1, 101 L2
done  out  1  one-cycle pulse at run completion
err  out  1  sticky protocol/range error
dbg_sel  in  3  readback bank select (same encoding as csel, 000 = image)
dbg_addr  in  AW  readback address
dbg_data  out  DW  readback data, combinational

Behaviour:
- Reset (reset=0): state=IDLE; ready=0, done=0, err=0. Memory arrays are not cleared.
- FSM states: IDLE, REQ, RUN, FIN.
  - IDLE: start=1 -> REQ, and ready=1 from the next cycle.
  - REQ: ready held at 1 until busy=1 is sampled, then -> RUN with ready=0 the same edge.
  - RUN: busy falling (1 then 0) -> FIN.
  - FIN: done=1 for exactly one cycle -> IDLE.
- start outside IDLE is ignored.
- Image load: img_we accepted only in IDLE. Writes at posedge. img_we in other states is dropped and sets err.
- idata = image[iaddr], combinational (zero-latency). The accelerator samples it the cycle after driving iaddr.
- cdata_rd = bank[csel][caddr_rd] when crd=1, combinational; 0 when crd=0.
- Bank write: at posedge when cwr=1, bank[csel][caddr_wr] <= cdata_wr.
- Read-during-write, same bank and address, same cycle: cdata_rd returns the old value.
- Range rules:
  - L0 banks use the full 4096 entries.
  - L1 address >= L1_DEPTH, or L2 address >= L2_DEPTH: write ignored, read returns 0, err=1.
  - csel 000/110/111 with crd or cwr: no access, cdata_rd=0, err=1.
- crd and cwr may both be 1 in the same cycle. csel applies to both accesses.
- Bank accesses are honoured in every state, not only RUN. The accelerator owns timing.
- err clears only on reset.
- Reset mid-run returns to IDLE immediately. Partially written bank contents are retained.

Optional Feature:
CONV_HOST_WDOG_EN.
- Defined: a 24-bit watchdog counts cycles in REQ and RUN and clears on entry to IDLE. At 2^24-1 it forces FIN (done pulse) and sets err.
- Undefined: no counter; REQ and RUN wait indefinitely.

Decomposition:
- Shared package conv_pkg holds:
  - csel encodings (CSEL_L0_K0=3'b001 ... CSEL_L2=3'b101)
  - DW and AW
  - L1/L2 depths
  - FSM state typedef
- One natural sub-module: conv_bank_ram, with parameterised depth, one posedge write port, one async read port, and one async debug read port. It is instantiated five times, plus once for the image (4096 deep).

Test Plan:
- Handshake: load image, start pulse -> ready=1 next cycle; hold busy=0 for 5 cycles -> ready stays 1; busy=1 -> ready=0 next edge; busy low -> done one cycle, state IDLE.
- Image read: img_we addr 0x041 data 20'h12345 -> iaddr=0x041 gives idata=20'h12345 same cycle; img_we during RUN -> image unchanged, err=1.
- Bank write/read: cwr csel=001 addr 0xFFF data 20'h0ABCD -> crd csel=001 addr 0xFFF returns 20'h0ABCD; same address with csel=010 returns the prior contents.
- Range/error: cwr csel=011 addr 0x400 -> no write, err=1; crd csel=110 -> cdata_rd=0, err=1.
- Read-during-write: L2 addr 0x7FF holds 20'h00001; same cycle cwr data 20'h00002 and crd -> cdata_rd=20'h00001, next cycle 20'h00002.
- Reset mid-run: assert reset in RUN -> ready=0, done=0, err=0, IDLE; previously written L0 data still readable via dbg_sel=001.
